// File: rtl/sram_burst_ctrl.sv
// Burst controller between the memory stage and an asynchronous SRAM: single-word
// writes and aligned BURST-word line-fill reads, each beat stretched over WAIT_CYCLES+1 clocks.
// Optional feature macro: SRAM_BYTE_WRITE_EN (adds byte_en and per-beat UB_N/LB_N masking).
module sram_burst_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int ADDR_W      = 18,
    parameter int BURST       = 2,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [31:0]               addr,
    input  logic [DATA_W-1:0]         wdata,
`ifdef SRAM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0]       byte_en,
`endif
    output logic [BURST*DATA_W-1:0]   rdata,
    output logic                      ready,
    inout  wire  [SRAM_DW-1:0]        SRAM_DQ,
    output logic [ADDR_W-1:0]         SRAM_ADDR,
    output logic                      SRAM_WE_N,
    output logic                      SRAM_OE_N,
    output logic                      SRAM_CE_N,
    output logic                      SRAM_UB_N,
    output logic                      SRAM_LB_N
);

    localparam int HALVES    = DATA_W / SRAM_DW;
    localparam int MAX_BEATS = BURST * HALVES;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam int WAIT_W    = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                    state_q;
    logic                      is_write_q;
    logic [WAIT_W-1:0]         wait_q;
    logic [BEAT_W-1:0]         beat_q;
    logic [BEAT_W-1:0]         last_beat_q;
    logic [ADDR_W-1:0]         addr_q;
    logic                      we_n_q;
    logic                      oe_n_q;
    logic                      ub_n_q;
    logic                      lb_n_q;
    logic                      dq_oe_q;
    logic [SRAM_DW-1:0]        dq_out_q;
    logic [BURST*DATA_W-1:0]   rdata_q;

    logic [31:0]               offset_s;
    logic [31:0]               word_s;
    logic [31:0]               start_word_s;
    logic [31:0]               start_full_s;
    logic [ADDR_W-1:0]         start_addr_d;
    logic [BEAT_W-1:0]         beat_next_s;
    logic [BEAT_W-1:0]         beat_sel_s;
    logic                      wait_last_s;
    logic                      beat_last_s;
    logic [SRAM_DW-1:0]        wr_slice_s;
    logic [1:0]                lane_n_s;
    logic                      unused_s;

`ifdef SRAM_BYTE_WRITE_EN
    // Active-low {UB_N, LB_N} for write beat b from the two byte enables covering it.
    function automatic logic [1:0] lane_mask_n(input logic [DATA_W/8-1:0] be,
                                               input logic [BEAT_W-1:0]   b);
        return ~{be[2*b+1], be[2*b]};
    endfunction
`endif

    // Start address and per-beat write data/lane selection.
    always_comb begin
        offset_s     = addr - 32'(BASE_ADDR);
        word_s       = {2'b00, offset_s[31:2]};
        start_word_s = wr_en ? word_s : (word_s & ~32'(BURST - 1));
        start_full_s = start_word_s * 32'(HALVES);
        start_addr_d = start_full_s[ADDR_W-1:0];
        beat_next_s  = beat_q + BEAT_W'(1);
        wait_last_s  = (wait_q == WAIT_W'(WAIT_CYCLES));
        beat_last_s  = (beat_q == last_beat_q);
        if (state_q == IDLE) begin
            beat_sel_s = BEAT_W'(0);
        end else begin
            beat_sel_s = beat_next_s;
        end
        wr_slice_s = wdata[beat_sel_s*SRAM_DW +: SRAM_DW];
`ifdef SRAM_BYTE_WRITE_EN
        lane_n_s = lane_mask_n(byte_en, beat_sel_s);
`else
        lane_n_s = 2'b00;
`endif
    end

    assign unused_s = ^{offset_s[1:0], start_full_s[31:ADDR_W]};

    // Transfer FSM with wait/beat counters and registered SRAM strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            wait_q      <= WAIT_W'(0);
            beat_q      <= BEAT_W'(0);
            last_beat_q <= BEAT_W'(0);
            addr_q      <= ADDR_W'(0);
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ub_n_q      <= 1'b0;
            lb_n_q      <= 1'b0;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= SRAM_DW'(0);
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        state_q     <= ACCESS;
                        is_write_q  <= wr_en;
                        wait_q      <= WAIT_W'(0);
                        beat_q      <= BEAT_W'(0);
                        last_beat_q <= wr_en ? BEAT_W'(HALVES - 1) : BEAT_W'(MAX_BEATS - 1);
                        addr_q      <= start_addr_d;
                        if (wr_en) begin
                            we_n_q   <= 1'b0;
                            oe_n_q   <= 1'b1;
                            dq_oe_q  <= 1'b1;
                            dq_out_q <= wr_slice_s;
                            {ub_n_q, lb_n_q} <= lane_n_s;
                        end else begin
                            we_n_q   <= 1'b1;
                            oe_n_q   <= 1'b0;
                            dq_oe_q  <= 1'b0;
                            {ub_n_q, lb_n_q} <= 2'b00;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!wait_last_s) begin
                        wait_q <= wait_q + WAIT_W'(1);
                        // Release WE_N one cycle before the beat ends so data is held past it.
                        if (is_write_q && (wait_q == WAIT_W'(WAIT_CYCLES - 1))) begin
                            we_n_q <= 1'b1;
                        end
                    end else begin
                        if (!is_write_q) begin
                            rdata_q[beat_q*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                        end
                        wait_q <= WAIT_W'(0);
                        if (beat_last_s) begin
                            state_q <= DONE;
                            beat_q  <= BEAT_W'(0);
                            we_n_q  <= 1'b1;
                            oe_n_q  <= 1'b1;
                            dq_oe_q <= 1'b0;
                            {ub_n_q, lb_n_q} <= 2'b00;
                        end else begin
                            beat_q <= beat_next_s;
                            addr_q <= addr_q + ADDR_W'(1);
                            if (is_write_q) begin
                                we_n_q   <= 1'b0;
                                dq_out_q <= wr_slice_s;
                                {ub_n_q, lb_n_q} <= lane_n_s;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ((state_q == IDLE) && !wr_en && !rd_en) || (state_q == DONE);
    assign rdata     = rdata_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: stimulus queues expected beats and transfer
// results; a negedge monitor pops and compares as the DUT presents them.
module tb_sram_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [63:0] rdata;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    always #5 clk = ~clk;

    sram_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
`ifdef SRAM_BYTE_WRITE_EN
        .byte_en   (byte_en),
`endif
        .rdata     (rdata),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_CE_N (ce_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    // Asynchronous SRAM model: drives on read, latches while WE_N is low.
    logic [15:0] mem [0:255];
    assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mem[2] = 16'h5555; mem[3] = 16'hAAAA;
        mem[4] = 16'h2222; mem[5] = 16'h1111;
        mem[6] = 16'h4444; mem[7] = 16'h3333;
    end

    always @(negedge clk) begin
        if (!rst && !we_n) begin
            if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    typedef struct { bit wr; logic [17:0] a; logic [15:0] d; logic [1:0] ubl; } beat_t;
    typedef struct { bit wr; int busy; logic [63:0] rd; } txn_t;
    beat_t beat_q[$];
    txn_t  txn_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic push_beat(input bit wr, input logic [17:0] a, input logic [15:0] d,
                             input logic [1:0] ubl);
        beat_t b;
        b.wr = wr; b.a = a; b.d = d; b.ubl = ubl;
        beat_q.push_back(b);
    endtask

    task automatic push_txn(input bit wr, input int busy, input logic [63:0] rd);
        txn_t t;
        t.wr = wr; t.busy = busy; t.rd = rd;
        txn_q.push_back(t);
    endtask

    // Monitor: beat starts, WE_N pulse width, address stability and transfer completion.
    bit          prev_we = 1'b1, prev_oe = 1'b1, oe_seen = 1'b0;
    logic [17:0] prev_addr = 18'd0;
    int          we_low = 0, busy_cnt = 0;
    always @(negedge clk) begin
        beat_t b;
        txn_t  t;
        if (rst) begin
            beat_q.delete();
            busy_cnt = 0; we_low = 0; oe_seen = 1'b0;
            prev_we = 1'b1; prev_oe = 1'b1; prev_addr = 18'd0;
        end else begin
            if (prev_we && !we_n) begin
                if (beat_q.size() == 0) note_fail("wbeat_unexpected");
                else begin
                    b = beat_q.pop_front();
                    chk("wbeat_kind", 64'(!b.wr), 64'd0);
                    chk("wbeat_addr", 64'(sram_addr), 64'(b.a));
                    chk("wbeat_dq", 64'(sram_dq), 64'(b.d));
                    chk("wbeat_ub_lb", 64'({ub_n, lb_n}), 64'(b.ubl));
                end
            end
            if (!we_n && !prev_we) chk("addr_stable_we_low", 64'(sram_addr), 64'(prev_addr));
            if (!we_n) we_low++;
            if (!prev_we && we_n) begin
                chk("we_low_len", 64'(we_low), 64'd3);
                we_low = 0;
            end
            if (!oe_n && (prev_oe || sram_addr != prev_addr)) begin
                oe_seen = 1'b1;
                if (beat_q.size() == 0) note_fail("rbeat_unexpected");
                else begin
                    b = beat_q.pop_front();
                    chk("rbeat_kind", 64'(b.wr), 64'd0);
                    chk("rbeat_addr", 64'(sram_addr), 64'(b.a));
                    chk("rbeat_ub_lb", 64'({ub_n, lb_n}), 64'd0);
                    chk("rbeat_we_n", 64'(we_n), 64'd1);
                    chk("rbeat_bus", 64'(sram_dq), 64'(mem[sram_addr[7:0]]));
                end
            end
            if (wr_en || rd_en) begin
                if (!ready) busy_cnt++;
                else if (txn_q.size() == 0) note_fail("txn_unexpected");
                else begin
                    t = txn_q.pop_front();
                    chk("txn_latency", 64'(busy_cnt), 64'(t.busy));
                    chk("txn_rdata", rdata, t.rd);
                    if (t.wr) chk("txn_oe_during_write", 64'(oe_seen), 64'd0);
                    busy_cnt = 0;
                    oe_seen = 1'b0;
                end
            end
            prev_we = we_n; prev_oe = oe_n; prev_addr = sram_addr;
        end
    end

    // Issue a request at cycle 0 and hold it until ready; returns just after the DONE edge.
    task automatic run(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        bit done = 1'b0;
        wr_en = wr; rd_en = rd; addr = a; wdata = d;
        #1 chk("ready_stall_cycle0", 64'(ready), 64'd0);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) note_fail("ready_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 32'd0; wdata = 32'd0; byte_en = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_we_n", 64'(we_n), 64'd1);
        chk("rst_oe_n", 64'(oe_n), 64'd1);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("ce_n_tied", 64'(ce_n), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Aligned two-word read from word offset 3 -> SRAM 4..7.
        for (int i = 4; i < 8; i++) push_beat(1'b0, 18'(i), 16'd0, 2'b00);
        push_txn(1'b0, 17, 64'h33334444_11112222);
        run(1'b0, 1'b1, 32'd1036, 32'd0);
        go_idle();

        // Single-word write at word offset 2 -> SRAM 4, 5.
        push_beat(1'b1, 18'd4, 16'hBEEF, 2'b00);
        push_beat(1'b1, 18'd5, 16'hDEAD, 2'b00);
        push_txn(1'b1, 9, 64'h33334444_11112222);
        run(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
        go_idle();
        chk("mem4", 64'(mem[4]), 64'h0000_0000_0000_BEEF);
        chk("mem5", 64'(mem[5]), 64'h0000_0000_0000_DEAD);

        // Simultaneous write and read: write wins.
        push_beat(1'b1, 18'd8, 16'hF00D, 2'b00);
        push_beat(1'b1, 18'd9, 16'hCAFE, 2'b00);
        push_txn(1'b1, 9, 64'h33334444_11112222);
        run(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
        go_idle();
        chk("mem8", 64'(mem[8]), 64'h0000_0000_0000_F00D);
        chk("mem9", 64'(mem[9]), 64'h0000_0000_0000_CAFE);

        // Back-to-back write then read with requests held.
        push_beat(1'b1, 18'd0, 16'h5678, 2'b00);
        push_beat(1'b1, 18'd1, 16'h1234, 2'b00);
        push_txn(1'b1, 9, 64'h33334444_11112222);
        for (int i = 0; i < 4; i++) push_beat(1'b0, 18'(i), 16'd0, 2'b00);
        push_txn(1'b0, 17, 64'hAAAA5555_12345678);
        run(1'b1, 1'b0, 32'd1024, 32'h12345678);
        run(1'b0, 1'b1, 32'd1028, 32'd0);
        go_idle();

        // Reset in cycle 5 of a read aborts it.
        push_beat(1'b0, 18'd4, 16'd0, 2'b00);
        rd_en = 1'b1; addr = 32'd1036;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; rd_en = 1'b0;
        #1;
        chk("abort_we_n", 64'(we_n), 64'd1);
        chk("abort_oe_n", 64'(oe_n), 64'd1);
        chk("abort_rdata", rdata, 64'd0);
        chk("abort_addr", 64'(sram_addr), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 4; i < 8; i++) push_beat(1'b0, 18'(i), 16'd0, 2'b00);
        push_txn(1'b0, 17, 64'h33334444_DEADBEEF);
        run(1'b0, 1'b1, 32'd1036, 32'd0);
        go_idle();

`ifdef SRAM_BYTE_WRITE_EN
        // Only byte 2 enabled: beat 0 fully masked, beat 1 low lane only.
        byte_en = 4'b0100;
        push_beat(1'b1, 18'd20, 16'hF00D, 2'b11);
        push_beat(1'b1, 18'd21, 16'hCAFE, 2'b10);
        push_txn(1'b1, 9, 64'h33334444_DEADBEEF);
        run(1'b1, 1'b0, 32'd1064, 32'hCAFEF00D);
        go_idle();
        chk("bw_mem20", 64'(mem[20]), 64'h0000_0000_0000_0014);
        chk("bw_mem21", 64'(mem[21]), 64'h0000_0000_0000_00FE);
        byte_en = 4'hF;
`endif

        repeat (3) @(posedge clk);
        chk("beat_queue_drained", 64'(beat_q.size()), 64'd0);
        chk("txn_queue_drained", 64'(txn_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Parametrised controller between the memory stage and the off-chip asynchronous SRAM. It splits each CPU word into SRAM_DW-wide beats and performs single-word writes and BURST-word aligned read bursts for line fills. Every SRAM beat is stretched over WAIT_CYCLES+1 clocks. The memory stage is stalled through a combinational `ready` until the transfer completes.

## Interface
- DATA_W, 32: CPU word width; multiple of SRAM_DW; HALVES = DATA_W/SRAM_DW.
- SRAM_DW, 16: SRAM data bus width.
- ADDR_W, 18: SRAM address width.
- BURST, 2: words per read; power of two, ≥1.
- WAIT_CYCLES, 3: extra clocks per beat; ≥1.
- BASE_ADDR, 1024: byte address mapped to SRAM location 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request, held until `ready`.
- rd_en  in  1  read request, held until `ready`.
- addr  in  32  byte address.
- wdata  in  DATA_W  write word.
- byte_en  in  DATA_W/8  byte mask; present only with SRAM_BYTE_WRITE_EN.
- rdata  out  BURST*DATA_W  burst read data; word k at [k*DATA_W +: DATA_W].
- ready  out  1  high when no transfer is pending.
- SRAM_DQ  inout  SRAM_DW  data bus.
- SRAM_ADDR  out  ADDR_W  beat address.
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes; all active-low.

## Operation
- States: IDLE, ACCESS, DONE.
  - IDLE→ACCESS when wr_en|rd_en.
  - ACCESS→DONE after the last cycle of the last beat.
  - DONE→IDLE unconditionally.
- Priority: write wins when wr_en and rd_en are both high; rd_en is ignored for that transfer.
- ready = (IDLE & ~wr_en & ~rd_en) | DONE. This is combinational, so the stall asserts in the request cycle.
- Word offset: wo = (addr − BASE_ADDR) >> 2.
  - Write: beats = HALVES, start = wo.
  - Read: beats = BURST*HALVES, start = wo & ~(BURST−1).
- Beat address: beat b uses SRAM_ADDR = (start*HALVES + b) truncated to ADDR_W. The low half of a word sits at the lower SRAM address.
- Each beat lasts WAIT_CYCLES+1 cycles, tracked by a wait counter and a beat counter.
- Write beat:
  - SRAM_WE_N is low for the first WAIT_CYCLES cycles and high on the final (hold) cycle.
  - SRAM_DQ drives wdata[b*SRAM_DW +: SRAM_DW] for the whole beat.
- Read beat:
  - SRAM_OE_N is low throughout ACCESS; SRAM_DQ is high-Z.
  - SRAM_DQ is captured on the clock edge ending the beat's final cycle into rdata[b*SRAM_DW +: SRAM_DW].
- rdata holds its value until overwritten by a later read. Writes never modify it.
- SRAM_CE_N is tied 0. UB_N/LB_N are 0 except as set by the macro.
- SRAM_DQ is high-Z in IDLE, DONE and during reads.
- Reset values: state IDLE, counters 0, rdata 0, SRAM_ADDR 0, SRAM_WE_N 1, SRAM_OE_N 1, DQ high-Z, ready = ~(wr_en|rd_en).
- Reset asserted mid-transfer aborts immediately, with the same values. A partially written word is not rolled back.

## Timing
- Cycle 0: request seen in IDLE; ready=0.
- Cycles 1..N: ACCESS, with N = beats*(WAIT_CYCLES+1).
- Cycle N+1: DONE, ready=1; rdata is valid.
- Defaults: write N=8, ready in cycle 9; read N=16, ready in cycle 17.
- A new request is accepted no earlier than cycle N+2 (IDLE).
- SRAM_ADDR changes only on beat boundaries, never while SRAM_WE_N is low.

## Configuration
- SRAM_BYTE_WRITE_EN defined:
  - byte_en port exists. Requires SRAM_DW=16.
  - During write beat b, LB_N = ~byte_en[2b] and UB_N = ~byte_en[2b+1].
  - A beat with both bytes masked still spends its cycles, but writes nothing.
  - Reads keep UB_N/LB_N at 0.
- Undefined: no byte_en port; UB_N/LB_N are always 0; every write is full-word.

## Test plan
- Write 0xDEADBEEF at addr 1024+8 → two beats at SRAM_ADDR 4, 5 with DQ 0xBEEF then 0xDEAD; WE_N low 3 cycles each; ready high in cycle 9.
- Read at addr 1024+12 with the SRAM model holding words 0x11112222, 0x33334444 at word offsets 2, 3 → beats at SRAM_ADDR 4..7; rdata = 0x33334444_11112222; ready in cycle 17.
- wr_en and rd_en high together → only the write occurs; rdata unchanged; OE_N stays 1.
- rst pulsed in cycle 5 of a read → WE_N=1, OE_N=1, rdata=0, DQ high-Z; the next request runs a full-length transfer.
- Back-to-back write then read, with requests held → the read starts in the cycle after DONE, and the bus is never driven during read beats.
- With SRAM_BYTE_WRITE_EN, byte_en=4'b0100 → beat 0 has UB_N=LB_N=1; beat 1 has LB_N=0, UB_N=1.
